memory_access_stage: RTL and testbench

- MEM stage of the 16-bit pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register.
- Performs data-RAM loads and stores and memory-mapped UART access (TX handshake, RX holding register).
- Produces MemReadDataM, the ALU-result passthrough and the gated control bits that the MEM/WB register latches.
- Raises stallM while a UART TX store cannot be accepted.

---
 rtl/memory_access_stage_pkg.sv | 18 +
 rtl/memory_access_stage_if.sv | 26 ++
 rtl/memory_access_stage_uart_mmio_port.sv | 76 +++++++
 rtl/memory_access_stage.sv | 79 +++++++
 tb/tb_memory_access_stage.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_access_stage_pkg.sv
// Shared constants and types for the MEM stage: UART window layout, STATUS bits, TX state.
package memory_access_stage_pkg;

    localparam logic [15:0] UART_BASE  = 16'hFF00;
    localparam logic [15:0] TXDATA_OFS = 16'd0;
    localparam logic [15:0] STATUS_OFS = 16'd1;
    localparam logic [15:0] RXDATA_OFS = 16'd2;

    localparam int unsigned STATUS_TX_BUSY    = 0;
    localparam int unsigned STATUS_RX_VALID   = 1;
    localparam int unsigned STATUS_RX_OVERRUN = 2;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_t;

endpackage

// File: rtl/memory_access_stage_if.sv
// UART link between the MEM stage (master) and the serial peripheral (slave).
interface memory_access_stage_if;

    logic [7:0] uart_tx_data;
    logic       uart_tx_valid;
    logic       uart_tx_ready;
    logic [7:0] uart_rx_data;
    logic       uart_rx_valid;

    modport master (
        output uart_tx_data,
        output uart_tx_valid,
        input  uart_tx_ready,
        input  uart_rx_data,
        input  uart_rx_valid
    );

    modport slave (
        input  uart_tx_data,
        input  uart_tx_valid,
        output uart_tx_ready,
        output uart_rx_data,
        output uart_rx_valid
    );

endinterface

// File: rtl/memory_access_stage_uart_mmio_port.sv
// Memory-mapped UART port: TX handshake FSM, RX holding register and the STATUS/RXDATA read words.
module uart_mmio_port
    import memory_access_stage_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tx_wr,
    input  logic                         rx_rd,
    input  logic [7:0]                   wdata,
    output logic                         stall,
    output logic [15:0]                  status_word,
    output logic [15:0]                  rxdata_word,
    memory_access_stage_if.master        uart
);

    tx_state_t  state;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_overrun;

    // A TX store arriving in the ready cycle is still stalled; it is taken once back in TX_IDLE.
    assign stall = tx_wr & (state == TX_BUSY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= TX_IDLE;
            uart.uart_tx_valid <= 1'b0;
            uart.uart_tx_data  <= '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (tx_wr) begin
                        uart.uart_tx_data  <= wdata;
                        uart.uart_tx_valid <= 1'b1;
                        state              <= TX_BUSY;
                    end
                end
                TX_BUSY: begin
                    if (uart.uart_tx_ready) begin
                        uart.uart_tx_valid <= 1'b0;
                        state              <= TX_IDLE;
                    end
                end
                default: begin
                    uart.uart_tx_valid <= 1'b0;
                    state              <= TX_IDLE;
                end
            endcase
        end
    end

    // A strobe coinciding with the RXDATA load wins over the clear and does not count as overrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else if (uart.uart_rx_valid) begin
            rx_byte    <= uart.uart_rx_data;
            rx_valid   <= 1'b1;
            rx_overrun <= rx_rd ? 1'b0 : (rx_overrun | rx_valid);
        end else if (rx_rd) begin
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end
    end

    always_comb begin
        status_word                    = '0;
        status_word[STATUS_TX_BUSY]    = (state == TX_BUSY);
        status_word[STATUS_RX_VALID]   = rx_valid;
        status_word[STATUS_RX_OVERRUN] = rx_overrun;
        rxdata_word                    = {8'h00, rx_byte};
    end

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: data RAM, address decode, UART MMIO and the gated controls for MEM/WB.
module memory_access_stage #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter logic [15:0] UART_BASE  = 16'hFF00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemWriteM,
    input  logic                  MemToRegM,
    input  logic                  RegWriteM,
    input  logic [3:0]            destAddM,
    input  logic [15:0]           alu_resultM,
    input  logic [15:0]           WriteDataM,
    output logic                  MemToRegMout,
    output logic                  RegWriteMout,
    output logic                  MemWriteMout,
    output logic [3:0]            destAddMout,
    output logic [15:0]           alu_resultMout,
    output logic [15:0]           MemReadDataM,
    output logic                  stallM,
    memory_access_stage_if.master uart
);

    import memory_access_stage_pkg::*;

    localparam logic [15:0] TXDATA_ADDR = UART_BASE + TXDATA_OFS;
    localparam logic [15:0] STATUS_ADDR = UART_BASE + STATUS_OFS;
    localparam logic [15:0] RXDATA_ADDR = UART_BASE + RXDATA_OFS;

    logic [15:0] mem [0:(1 << DEPTH_LOG2) - 1];

    logic        ram_hit;
    logic        txdata_hit;
    logic        status_hit;
    logic        rxdata_hit;
    logic [15:0] status_word;
    logic [15:0] rxdata_word;

    assign ram_hit    = (alu_resultM[15:DEPTH_LOG2] == '0);
    assign txdata_hit = (alu_resultM == TXDATA_ADDR);
    assign status_hit = (alu_resultM == STATUS_ADDR);
    assign rxdata_hit = (alu_resultM == RXDATA_ADDR);

    always_ff @(posedge clk) begin
        if (MemWriteM && ram_hit) begin
            mem[alu_resultM[DEPTH_LOG2-1:0]] <= WriteDataM;
        end
    end

    uart_mmio_port u_uart (
        .clk         (clk),
        .reset       (reset),
        .tx_wr       (MemWriteM & txdata_hit),
        .rx_rd       (MemToRegM & rxdata_hit),
        .wdata       (WriteDataM[7:0]),
        .stall       (stallM),
        .status_word (status_word),
        .rxdata_word (rxdata_word),
        .uart        (uart)
    );

    always_comb begin
        MemReadDataM = '0;
        if (ram_hit) begin
            MemReadDataM = mem[alu_resultM[DEPTH_LOG2-1:0]];
        end else if (status_hit) begin
            MemReadDataM = status_word;
        end else if (rxdata_hit) begin
            MemReadDataM = rxdata_word;
        end
    end

    assign MemToRegMout   = MemToRegM;
    assign destAddMout    = destAddM;
    assign alu_resultMout = alu_resultM;
    assign RegWriteMout   = RegWriteM & ~stallM;
    assign MemWriteMout   = MemWriteM & ~stallM;

endmodule

// File: tb/tb_memory_access_stage.sv
// Randomized bench for memory_access_stage against a transaction-level model of RAM and UART.
module tb_memory_access_stage;

    localparam logic [15:0] BASE = 16'hFF00;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWriteM = 1'b0;
    logic        MemToRegM = 1'b0;
    logic        RegWriteM = 1'b0;
    logic [3:0]  destAddM = '0;
    logic [15:0] alu_resultM = '0;
    logic [15:0] WriteDataM = '0;
    logic        MemToRegMout;
    logic        RegWriteMout;
    logic        MemWriteMout;
    logic [3:0]  destAddMout;
    logic [15:0] alu_resultMout;
    logic [15:0] MemReadDataM;
    logic        stallM;

    memory_access_stage_if uart_bus ();

    memory_access_stage #(.DEPTH_LOG2(8), .UART_BASE(BASE)) dut (
        .clk            (clk),
        .reset          (reset),
        .MemWriteM      (MemWriteM),
        .MemToRegM      (MemToRegM),
        .RegWriteM      (RegWriteM),
        .destAddM       (destAddM),
        .alu_resultM    (alu_resultM),
        .WriteDataM     (WriteDataM),
        .MemToRegMout   (MemToRegMout),
        .RegWriteMout   (RegWriteMout),
        .MemWriteMout   (MemWriteMout),
        .destAddMout    (destAddMout),
        .alu_resultMout (alu_resultMout),
        .MemReadDataM   (MemReadDataM),
        .stallM         (stallM),
        .uart           (uart_bus)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Model: RAM image with written flags, one pending TX byte, RX byte with valid/overrun flags.
    logic [15:0] m_ram [256];
    bit          m_known [256];
    bit          m_busy;
    logic [7:0]  m_txb;
    logic [7:0]  m_rxb;
    bit          m_rxv;
    bit          m_ovr;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_txb  = 8'h00;
        m_rxb  = 8'h00;
        m_rxv  = 0;
        m_ovr  = 0;
    endtask

    // Drive one pipeline cycle, check outputs mid-cycle, then advance model and DUT together.
    task automatic step(input bit we, input bit ld, input bit rw, input logic [3:0] dest,
                        input logic [15:0] addr, input logic [15:0] wd,
                        input bit rdy, input bit rxs, input logic [7:0] rxd);
        bit          is_ram;
        bit          exp_stall;
        bit          rd_known;
        bit          clear;
        bit          had;
        logic [15:0] exp_rd;
        MemWriteM = we;
        MemToRegM = ld;
        RegWriteM = rw;
        destAddM = dest;
        alu_resultM = addr;
        WriteDataM = wd;
        uart_bus.uart_tx_ready = rdy;
        uart_bus.uart_rx_valid = rxs;
        uart_bus.uart_rx_data = rxd;
        @(negedge clk);
        is_ram    = (addr < 16'd256);
        exp_stall = we && (addr == BASE) && m_busy;
        rd_known  = 1;
        exp_rd    = 16'h0000;
        if (is_ram) begin
            rd_known = m_known[addr[7:0]];
            exp_rd   = m_ram[addr[7:0]];
        end else if (addr == BASE + 16'd1) begin
            exp_rd = {13'b0, m_ovr, m_rxv, m_busy};
        end else if (addr == BASE + 16'd2) begin
            exp_rd = {8'h00, m_rxb};
        end
        check_eq("stallM", 16'(stallM), 16'(exp_stall));
        check_eq("RegWriteMout", 16'(RegWriteMout), 16'(rw && !exp_stall));
        check_eq("MemWriteMout", 16'(MemWriteMout), 16'(we && !exp_stall));
        check_eq("MemToRegMout", 16'(MemToRegMout), 16'(ld));
        check_eq("destAddMout", 16'(destAddMout), 16'(dest));
        check_eq("alu_resultMout", alu_resultMout, addr);
        check_eq("uart_tx_valid", 16'(uart_bus.uart_tx_valid), 16'(m_busy));
        check_eq("uart_tx_data", 16'(uart_bus.uart_tx_data), 16'(m_txb));
        if (rd_known) check_eq("MemReadDataM", MemReadDataM, exp_rd);
        if (we && is_ram) begin
            m_ram[addr[7:0]]   = wd;
            m_known[addr[7:0]] = 1;
        end
        if (m_busy) begin
            if (rdy) m_busy = 0;
        end else if (we && addr == BASE) begin
            m_busy = 1;
            m_txb  = wd[7:0];
        end
        clear = ld && (addr == BASE + 16'd2);
        had   = m_rxv;
        if (clear) begin
            m_rxv = 0;
            m_ovr = 0;
        end
        if (rxs) begin
            if (had && !clear) m_ovr = 1;
            m_rxb = rxd;
            m_rxv = 1;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 7))
            0, 1, 2: return 16'($urandom_range(0, 15));
            3:       return BASE;
            4:       return BASE + 16'd1;
            5:       return BASE + 16'd2;
            6:       return BASE + 16'd3;
            default: return 16'h1234;
        endcase
    endfunction

    task automatic random_steps(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            step(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)), pick_addr(),
                 16'($urandom), ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2),
                 8'($urandom));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_known[i] = 0;
        model_reset();
        uart_bus.uart_tx_ready = 1'b0;
        uart_bus.uart_rx_valid = 1'b0;
        uart_bus.uart_rx_data = 8'h00;

        // Reset state
        MemToRegM = 1'b1;
        alu_resultM = BASE + 16'd1;
        #12;
        check_eq("rst_tx_valid", 16'(uart_bus.uart_tx_valid), 16'h0000);
        check_eq("rst_tx_data", 16'(uart_bus.uart_tx_data), 16'h0000);
        check_eq("rst_status", MemReadDataM, 16'h0000);
        check_eq("rst_stall", 16'(stallM), 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // RAM store/load, unmapped load and store
        step(1, 0, 0, 4'h1, 16'h0010, 16'hBEEF, 0, 0, 8'h00);
        step(0, 1, 1, 4'h2, 16'h0010, 16'h0000, 0, 0, 8'h00);
        step(1, 0, 0, 4'h3, 16'h1234, 16'h5555, 0, 0, 8'h00);
        step(0, 1, 1, 4'h4, 16'h1234, 16'h0000, 0, 0, 8'h00);
        step(0, 1, 1, 4'h4, 16'h0034, 16'h0000, 0, 0, 8'h00);

        // TX with delayed ready, then back-to-back stores
        step(1, 0, 0, 4'h0, BASE, 16'h0041, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 4'h5, BASE + 16'd1, 16'h0000, 0, 0, 8'h00);
        step(0, 1, 1, 4'h5, BASE + 16'd1, 16'h0000, 1, 0, 8'h00);
        step(0, 1, 1, 4'h5, BASE + 16'd1, 16'h0000, 0, 0, 8'h00);
        step(1, 0, 1, 4'h0, BASE, 16'h0041, 0, 0, 8'h00);
        step(1, 0, 1, 4'h0, BASE, 16'h0042, 0, 0, 8'h00);
        step(1, 0, 1, 4'h0, BASE, 16'h0042, 1, 0, 8'h00);
        step(1, 0, 1, 4'h0, BASE, 16'h0042, 0, 0, 8'h00);
        step(0, 0, 0, 4'h0, 16'h0000, 16'h0000, 1, 0, 8'h00);

        // RX: single byte, overrun, strobe coincident with read
        step(0, 0, 0, 4'h0, 16'h0000, 16'h0000, 0, 1, 8'h5A);
        step(0, 1, 1, 4'h6, BASE + 16'd1, 16'h0000, 0, 0, 8'h00);
        step(0, 1, 1, 4'h6, BASE + 16'd2, 16'h0000, 0, 0, 8'h00);
        step(0, 1, 1, 4'h6, BASE + 16'd1, 16'h0000, 0, 0, 8'h00);
        step(0, 0, 0, 4'h0, 16'h0000, 16'h0000, 0, 1, 8'h11);
        step(0, 0, 0, 4'h0, 16'h0000, 16'h0000, 0, 1, 8'h22);
        step(0, 1, 1, 4'h7, BASE + 16'd1, 16'h0000, 0, 0, 8'h00);
        step(0, 1, 1, 4'h7, BASE + 16'd2, 16'h0000, 0, 1, 8'h33);
        step(0, 1, 1, 4'h7, BASE + 16'd1, 16'h0000, 0, 0, 8'h00);
        step(0, 1, 1, 4'h7, BASE + 16'd2, 16'h0000, 0, 0, 8'h00);

        random_steps(600);

        // Asynchronous reset while TX is busy and an RX byte is held
        step(1, 0, 0, 4'h0, BASE, 16'h0077, 0, 0, 8'h00);
        step(0, 0, 0, 4'h0, 16'h0000, 16'h0000, 0, 1, 8'h99);
        MemWriteM = 1'b1;
        MemToRegM = 1'b0;
        alu_resultM = BASE;
        uart_bus.uart_tx_ready = 1'b0;
        uart_bus.uart_rx_valid = 1'b0;
        #1;
        check_eq("pre_rst_stall", 16'(stallM), 16'h0001);
        reset = 1'b0;
        #1;
        check_eq("async_rst_stall", 16'(stallM), 16'h0000);
        check_eq("async_rst_tx_valid", 16'(uart_bus.uart_tx_valid), 16'h0000);
        MemWriteM = 1'b0;
        MemToRegM = 1'b1;
        alu_resultM = BASE + 16'd1;
        #1;
        check_eq("async_rst_status", MemReadDataM, 16'h0000);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        random_steps(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
